flopoco_facc_4_5: RTL and testbench

Streaming floating-point accumulator for the FloPoCo 4/5 format. It sits directly downstream of `fmul` and consumes its 12-bit products as a valid/ready stream. It sums each `in_last`-terminated packet and emits one rounded sum plus a term count per packet. It is the reduction stage of dot-product datapaths.

---
 rtl/flopoco_fp_pkg.sv | 30 +++
 rtl/flopoco_fadd_4_5_comb.sv | 97 +++++++++
 rtl/flopoco_facc_4_5.sv | 68 ++++++
 tb/tb_flopoco_facc_4_5.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/flopoco_fp_pkg.sv
// flopoco_fp_pkg: shared definitions for FloPoCo-format arithmetic blocks.
//   Word layout: {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
//   Provides exception encodings, field-position helpers, the exponent bias
//   and the accumulator FSM state type.
package flopoco_fp_pkg;

   localparam logic [1:0] EXC_ZERO   = 2'b00;
   localparam logic [1:0] EXC_NORMAL = 2'b01;
   localparam logic [1:0] EXC_INF    = 2'b10;
   localparam logic [1:0] EXC_NAN    = 2'b11;

   typedef enum logic {ACC, HOLD} acc_state_t;

   function automatic int exc_lsb(input int we, input int wf);
      return we + wf + 1;
   endfunction

   function automatic int sign_pos(input int we, input int wf);
      return we + wf;
   endfunction

   function automatic int exp_lsb(input int wf);
      return wf;
   endfunction

   function automatic int bias(input int we);
      return (1 << (we - 1)) - 1;
   endfunction

endpackage

// File: rtl/flopoco_fadd_4_5_comb.sv
// flopoco_fadd_4_5_comb: combinational FloPoCo WE/WF adder, round to nearest even.
//   a, b : operands {exc, sign, exp, frac}
//   y    : sum in the same format
//   Specials (NaN, inf, zero) take priority over the normal datapath.
module flopoco_fadd_4_5_comb
   import flopoco_fp_pkg::*;
#(
   parameter int WE = 4,
   parameter int WF = 5
) (
   input  logic [2+WE+WF:0] a,
   input  logic [2+WE+WF:0] b,
   output logic [2+WE+WF:0] y
);

   localparam int XL = exc_lsb(WE, WF);
   localparam int SP = sign_pos(WE, WF);
   localparam int EL = exp_lsb(WF);
   localparam int M  = WF + 1;
   // Alignment headroom wide enough that every shifted-out bit reaches sticky.
   localparam int SH = (1 << WE) + 2;
   localparam int SW = M + 4;
   localparam int LW = $clog2(SW + 1);

   logic [1:0]      xa, xb;
   logic            sa, sb;
   logic [WE-1:0]   ea, eb;
   logic [WF-1:0]   fa, fb;

   assign xa = a[XL +: 2];
   assign xb = b[XL +: 2];
   assign sa = a[SP];
   assign sb = b[SP];
   assign ea = a[EL +: WE];
   assign eb = b[EL +: WE];
   assign fa = a[WF-1:0];
   assign fb = b[WF-1:0];

   logic            swap, sl, sub;
   logic [WE-1:0]   el, es, d;
   logic [M-1:0]    sig_l, sig_s;
   logic [M+SH-1:0] b_ext;
   logic [M+2:0]    aa, bb;
   logic [SW-1:0]   s, n;
   logic [LW-1:0]   lz;
   logic            g, st, up;
   logic [WF:0]     frac_r;
   logic [WE+1:0]   e_r;
   logic [2+WE+WF:0] y_norm;
   logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   always_comb begin
      swap  = {eb, fb} > {ea, fa};
      el    = swap ? eb : ea;
      es    = swap ? ea : eb;
      sig_l = {1'b1, swap ? fb : fa};
      sig_s = {1'b1, swap ? fa : fb};
      sl    = swap ? sb : sa;
      sub   = sa ^ sb;
      d     = el - es;
      b_ext = {sig_s, {SH{1'b0}}} >> d;
      // Keep guard and round bits, fold everything below into sticky.
      bb    = {b_ext[M+SH-1 -: M+2], |b_ext[SH-3:0]};
      aa    = {sig_l, 3'b000};
      s     = sub ? {1'b0, aa} - {1'b0, bb} : {1'b0, aa} + {1'b0, bb};
      lz    = LW'(SW);
      for (int i = 0; i < SW; i++)
         if (s[i]) lz = LW'(SW - 1 - i);
      n      = s << lz;
      g      = n[3];
      st     = |n[2:0];
      up     = g & (st | n[4]);
      // Carry out of the fraction means the significand rounded up to 2.0.
      frac_r = {1'b0, n[SW-2:4]} + (WF+1)'(up);
      e_r    = (WE+2)'(el) + (WE+2)'(1) - (WE+2)'(lz) + (WE+2)'(frac_r[WF]);
      y_norm = !n[SW-1] ? '0
             : e_r[WE+1] ? {EXC_ZERO, sl, {(WE+WF){1'b0}}}
             : e_r[WE]   ? {EXC_INF, sl, {(WE+WF){1'b0}}}
             : {EXC_NORMAL, sl, e_r[WE-1:0], frac_r[WF-1:0]};
   end

   assign a_nan  = xa == EXC_NAN;
   assign b_nan  = xb == EXC_NAN;
   assign a_inf  = xa == EXC_INF;
   assign b_inf  = xb == EXC_INF;
   assign a_zero = xa == EXC_ZERO;
   assign b_zero = xb == EXC_ZERO;

   assign y = (a_nan | b_nan | (a_inf & b_inf & (sa ^ sb))) ? {EXC_NAN, 1'b0, {(WE+WF){1'b0}}}
            : a_inf             ? {EXC_INF, sa, {(WE+WF){1'b0}}}
            : b_inf             ? {EXC_INF, sb, {(WE+WF){1'b0}}}
            : (a_zero & b_zero) ? {EXC_ZERO, sa & sb, {(WE+WF){1'b0}}}
            : a_zero            ? b
            : b_zero            ? a
            : y_norm;

endmodule

// File: rtl/flopoco_facc_4_5.sv
// flopoco_facc_4_5: streaming packet accumulator for FloPoCo WE/WF words.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data term, in_last ends packet
//   out_valid/out_ready : output handshake, out_data sum, out_count terms
//   One term per cycle while accumulating; the sum is held until taken.
module flopoco_facc_4_5
   import flopoco_fp_pkg::*;
#(
   parameter int WE    = 4,
   parameter int WF    = 5,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2+WE+WF:0]  in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2+WE+WF:0]  out_data,
   output logic [CNT_W-1:0]  out_count
);

   acc_state_t        state, state_nx;
   logic [2+WE+WF:0]  acc, sum;
   logic [CNT_W-1:0]  cnt, cnt_inc;
   logic              accept;

   flopoco_fadd_4_5_comb #(.WE(WE), .WF(WF)) u_add (
      .a(acc),
      .b(in_data),
      .y(sum)
   );

   assign cnt_inc = &cnt ? cnt : cnt + 1'b1;

   always_comb begin
      in_ready  = state == ACC;
      out_valid = state == HOLD;
      accept    = in_valid & in_ready;
      state_nx  = (accept & in_last)      ? HOLD
                : (out_valid & out_ready) ? ACC
                : state;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ACC;
         acc       <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_count <= '0;
      end else begin
         state <= state_nx;
         if (accept && in_last) begin
            out_data  <= sum;
            out_count <= cnt_inc;
            acc       <= '0;
            cnt       <= '0;
         end else if (accept) begin
            acc <= sum;
            cnt <= cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_flopoco_facc_4_5.sv
// tb_flopoco_facc_4_5: directed self-checking bench for the accumulator and its adder.
module tb_flopoco_facc_4_5;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        in_valid = 0;
   logic        in_ready;
   logic [11:0] in_data = '0;
   logic        in_last = 0;
   logic        out_valid;
   logic        out_ready = 0;
   logic [11:0] out_data;
   logic [7:0]  out_count;
   logic [11:0] ua = '0, ub = '0, uy;
   int          errs = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   flopoco_facc_4_5 #(.WE(4), .WF(5), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
   );

   flopoco_fadd_4_5_comb #(.WE(4), .WF(5)) u_add (.a(ua), .b(ub), .y(uy));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic add_vec(input string tag, input logic [11:0] a, input logic [11:0] b, input logic [11:0] exp);
      ua = a;
      ub = b;
      #1;
      check(tag, uy, exp);
   endtask

   task automatic send(input logic [11:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      in_valid = 1;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      #1;
      in_valid = 0;
      in_last  = 0;
   endtask

   task automatic expect_out(input string tag, input logic [11:0] d, input logic [7:0] c);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, d);
      check({tag, "_count"}, out_count, c);
      @(negedge clk);
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      check({tag, "_ready_after"}, in_ready, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      add_vec("add_1p1", 12'h4E0, 12'h4E0, 12'h500);
      add_vec("add_2p1", 12'h500, 12'h4E0, 12'h510);
      add_vec("add_cancel", 12'h4E0, 12'h6E0, 12'h000);
      add_vec("add_neg", 12'h6E0, 12'h6E0, 12'h700);
      add_vec("add_ovf", 12'h5FF, 12'h5FF, 12'h800);
      add_vec("add_tie_even", 12'h4E0, 12'h420, 12'h4E0);
      add_vec("add_tie_up", 12'h4E1, 12'h420, 12'h4E2);
      add_vec("add_sub_round", 12'h4E0, 12'h641, 12'h4DE);
      add_vec("add_sticky", 12'h4E0, 12'h401, 12'h4E0);
      add_vec("add_underflow", 12'h400, 12'h601, 12'h200);
      add_vec("add_nzero", 12'h200, 12'h200, 12'h200);
      add_vec("add_mixzero", 12'h200, 12'h000, 12'h000);
      add_vec("add_zero_x", 12'h000, 12'h4E5, 12'h4E5);
      add_vec("add_ninf", 12'hA00, 12'h4E0, 12'hA00);
      add_vec("add_inf_ninf", 12'hA00, 12'h800, 12'hC00);

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_count", out_count, 0);
      @(negedge clk);
      rst_n = 1;

      send(12'h4E0, 0);
      send(12'h4E0, 0);
      check("p3_no_valid_early", out_valid, 0);
      send(12'h4E0, 1);
      expect_out("p3", 12'h510, 3);

      send(12'h4E0, 0); send(12'h6E0, 1); expect_out("cancel", 12'h000, 2);
      send(12'h5FF, 0); send(12'h5FF, 1); expect_out("ovf", 12'h800, 2);
      send(12'h4E0, 0); send(12'h420, 1); expect_out("tie_even", 12'h4E0, 2);
      send(12'h4E1, 0); send(12'h420, 1); expect_out("tie_up", 12'h4E2, 2);
      send(12'h800, 0); send(12'hA00, 1); expect_out("inf_ninf", 12'hC00, 2);
      send(12'h800, 0); send(12'h4E0, 1); expect_out("inf_x", 12'h800, 2);
      send(12'h4E0, 0); send(12'hC00, 0); send(12'h4E0, 1); expect_out("nan_mid", 12'hC00, 3);

      send(12'h4E0, 0);
      send(12'h4E0, 1);
      in_valid = 1;
      in_data  = 12'h4E1;
      in_last  = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         check("bp_out_data", out_data, 12'h500);
      end
      @(negedge clk);
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      check("bp_hs_valid", out_valid, 0);
      check("bp_hs_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 0;
      in_last  = 0;
      expect_out("bp_next", 12'h4E1, 1);

      send(12'h4E0, 0);
      send(12'h4E0, 0);
      @(negedge clk);
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("mid_rst_no_valid", out_valid, 0);
      end
      send(12'h500, 1);
      expect_out("after_rst", 12'h500, 1);

      for (int i = 0; i < 299; i++) send(12'h000, 0);
      send(12'h4E0, 1);
      expect_out("sat", 12'h4E0, 255);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
